// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl
// Main control FSM for the multicycle MIPS datapath. Each instruction is
// sequenced through fetch, decode, execute, memory and writeback. The FSM
// drives the datapath mux selects and write enables, and produces the 3-bit
// alu_op used by the ALU control decoder. FETCH, MEMREAD and MEMWRITE wait
// on mem_ready, so the FSM stalls while memory is slow.
//
// Ports
//   clk            system clock, rising edge
//   rst            synchronous active-high reset
//   opcode[5:0]    instr[31:26] from IR, stable from DECODE until FETCH
//   mem_ready      memory access completes this cycle
//   pc_write       unconditional PC load
//   pc_write_cond  PC load if ALU zero (branch)
//   pc_source[1:0] 00 ALU result, 01 ALUOut, 10 jump target
//   iord           0 PC address, 1 ALUOut address
//   mem_read       memory read
//   mem_write      memory write
//   ir_write       IR load
//   mem_to_reg     1 selects MDR as register write data
//   reg_dst        1 rd, 0 rt
//   reg_write      register file write
//   alu_src_a      0 PC, 1 A
//   alu_src_b[1:0] 00 B, 01 const 4, 10 imm, 11 imm<<2
//   alu_op[2:0]    000 add, 001 sub, 010 R-type funct, 011 and, 100 or
//   zero_ext       immediate is zero-extended (andi/ori)
//   illegal_op     unsupported opcode seen in DECODE
//   state[3:0]     current state, for debug
module mips_multicycle_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic [1:0] pc_source,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_op,
  output logic       zero_ext,
  output logic       illegal_op,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADDR  = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXEC     = 4'd6,
    RWB      = 4'd7,
    BRANCH   = 4'd8,
    JUMP     = 4'd9,
    IEXEC    = 4'd10,
    IWB      = 4'd11
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;

  state_t state_q;
  state_t state_d;
  logic   is_logic_imm;

  // andi/ori take a zero-extended immediate in both IEXEC and IWB.
  assign is_logic_imm = (opcode == OP_ANDI) || (opcode == OP_ORI);
  assign state        = state_q;

  // State register. Reset wins over everything, including a memory stall,
  // so a hung access can always be abandoned.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and output decode. Every output starts at 0 and each state
  // only raises what it needs. Stall states hold themselves until mem_ready,
  // and since their outputs depend only on the state (plus mem_ready for the
  // fetch strobes) they stay constant for the whole stall.
  always_comb begin
    state_d       = FETCH;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = 2'b00;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 3'b000;
    zero_ext      = 1'b0;
    illegal_op    = 1'b0;

    case (state_q)
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        // IR and PC load only in the cycle the read completes, so each
        // fetch produces exactly one pulse however long it stalls.
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        state_d   = mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        alu_src_b = 2'b11;
        case (opcode)
          OP_R:                     state_d = EXEC;
          OP_LW, OP_SW:             state_d = MEMADDR;
          OP_BEQ:                   state_d = BRANCH;
          OP_J:                     state_d = JUMP;
          OP_ADDI, OP_ANDI, OP_ORI: state_d = IEXEC;
          default: begin
            state_d    = FETCH;
            illegal_op = 1'b1;
          end
        endcase
      end
      MEMADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        if (opcode == OP_LW) begin
          state_d = MEMREAD;
        end else if (opcode == OP_SW) begin
          state_d = MEMWRITE;
        end
      end
      MEMREAD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        state_d  = mem_ready ? MEMWB : MEMREAD;
      end
      MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      MEMWRITE: begin
        // mem_write stays up for the whole stall; memory commits on the
        // mem_ready cycle.
        mem_write = 1'b1;
        iord      = 1'b1;
        state_d   = mem_ready ? FETCH : MEMWRITE;
      end
      EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 3'b010;
        state_d   = RWB;
      end
      RWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 3'b001;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
      end
      JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
      end
      IEXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        zero_ext  = is_logic_imm;
        if (opcode == OP_ANDI) begin
          alu_op = 3'b011;
        end else if (opcode == OP_ORI) begin
          alu_op = 3'b100;
        end
        state_d = IWB;
      end
      IWB: begin
        reg_write = 1'b1;
        zero_ext  = is_logic_imm;
      end
      default: begin
        state_d = FETCH;
      end
    endcase

    // Nothing may be written while reset is held, even if the state
    // register still shows a writing state before the reset edge.
    if (rst) begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      ir_write      = 1'b0;
      mem_write     = 1'b0;
      reg_write     = 1'b0;
      illegal_op    = 1'b0;
    end
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb_mips_multicycle_ctrl
// Self-checking bench for mips_multicycle_ctrl. A queue-based model tracks
// the instruction path each opcode takes; the expected outputs for every
// cycle are derived from the model state with per-output rules. Directed
// sequences add hand-computed latency and pulse-count expectations.
module tb_mips_multicycle_ctrl;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_BAD  = 6'b111111;

  logic       clk;
  logic       rst;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write;
  logic       pc_write_cond;
  logic [1:0] pc_source;
  logic       iord;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       mem_to_reg;
  logic       reg_dst;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_op;
  logic       zero_ext;
  logic       illegal_op;
  logic [3:0] state;

  int total;
  int bad;
  bit checks_on;

  int exp_state;
  int path[$];

  int cnt_ir_write;
  int cnt_mem_write;
  int cnt_illegal;
  logic [2:0] seen_alu_op   [16];
  logic [1:0] seen_pc_source[16];
  logic       seen_zext     [16];
  logic       seen_pc_write [16];
  logic       seen_pc_wcond [16];
  logic       seen_reg_dst  [16];
  logic       seen_reg_write[16];

  mips_multicycle_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .opcode        (opcode),
    .mem_ready     (mem_ready),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .pc_source     (pc_source),
    .iord          (iord),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .mem_to_reg    (mem_to_reg),
    .reg_dst       (reg_dst),
    .reg_write     (reg_write),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .zero_ext      (zero_ext),
    .illegal_op    (illegal_op),
    .state         (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outputs for one cycle, written output by output from the
  // state number each signal belongs to.
  function automatic logic [22:0] model_outputs(input int s, input logic [5:0] op,
                                                input logic mr, input logic r);
    logic pw, pwc, io, mrd, mwr, irw, m2r, rdst, rw, asa, ze, ill;
    logic [1:0] psrc, asb;
    logic [2:0] aop;
    logic is_andi, is_ori, legal;
    logic [3:0] s4;
    is_andi = (op == OP_ANDI);
    is_ori  = (op == OP_ORI);
    legal   = (op == OP_R) || (op == OP_LW) || (op == OP_SW) || (op == OP_BEQ) ||
              (op == OP_J) || (op == OP_ADDI) || is_andi || is_ori;
    pw   = !r && ((s == 0 && mr) || s == 9);
    pwc  = !r && (s == 8);
    psrc = (s == 8) ? 2'b01 : (s == 9) ? 2'b10 : 2'b00;
    io   = (s == 3) || (s == 5);
    mrd  = (s == 0) || (s == 3);
    mwr  = !r && (s == 5);
    irw  = !r && (s == 0) && mr;
    m2r  = (s == 4);
    rdst = (s == 7);
    rw   = !r && (s == 4 || s == 7 || s == 11);
    asa  = (s == 2) || (s == 6) || (s == 8) || (s == 10);
    asb  = (s == 0) ? 2'b01 : (s == 1) ? 2'b11 : (s == 2 || s == 10) ? 2'b10 : 2'b00;
    aop  = (s == 6) ? 3'b010 : (s == 8) ? 3'b001 :
           (s == 10 && is_andi) ? 3'b011 : (s == 10 && is_ori) ? 3'b100 : 3'b000;
    ze   = (s == 10 || s == 11) && (is_andi || is_ori);
    ill  = !r && (s == 1) && !legal;
    s4   = s[3:0];
    return {pw, pwc, psrc, io, mrd, mwr, irw, m2r, rdst, rw, asa, asb, aop, ze, ill, s4};
  endfunction

  // Model: on leaving FETCH the whole remaining path for the opcode is
  // queued; stall states hold while mem_ready is low; an empty path means
  // the instruction is done and the next cycle is FETCH.
  always @(posedge clk) begin
    if (rst) begin
      exp_state = 0;
      path.delete();
    end else if (exp_state == 0) begin
      if (mem_ready) begin
        case (opcode)
          OP_R:                     path = '{1, 6, 7};
          OP_LW:                    path = '{1, 2, 3, 4};
          OP_SW:                    path = '{1, 2, 5};
          OP_BEQ:                   path = '{1, 8};
          OP_J:                     path = '{1, 9};
          OP_ADDI, OP_ANDI, OP_ORI: path = '{1, 10, 11};
          default:                  path = '{1};
        endcase
        exp_state = path.pop_front();
      end
    end else if ((exp_state == 3 || exp_state == 5) && !mem_ready) begin
      exp_state = exp_state;
    end else if (path.size() == 0) begin
      exp_state = 0;
    end else begin
      exp_state = path.pop_front();
    end
  end

  // Per-cycle compare of every output against the model.
  always @(negedge clk) begin
    logic [22:0] got;
    logic [22:0] want;
    if (checks_on) begin
      got  = {pc_write, pc_write_cond, pc_source, iord, mem_read, mem_write, ir_write,
              mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, zero_ext,
              illegal_op, state};
      want = model_outputs(exp_state, opcode, mem_ready, rst);
      total++;
      if (got !== want) begin
        bad++;
        $display("[TB] FAIL cycle_outputs t=%0t got=%h want=%h (model state %0d)",
                 $time, got, want, exp_state);
      end
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s got=%0d want=%0d", name, actual, expected);
    end
  endtask

  // Drive one cycle's inputs, let outputs settle, and record what was seen.
  task automatic applyStimulus(input logic r, input logic [5:0] op, input logic mr);
    rst       = r;
    opcode    = op;
    mem_ready = mr;
    #2;
    if (ir_write === 1'b1)   cnt_ir_write++;
    if (mem_write === 1'b1)  cnt_mem_write++;
    if (illegal_op === 1'b1) cnt_illegal++;
    if (!$isunknown(state)) begin
      seen_alu_op[state]    = alu_op;
      seen_pc_source[state] = pc_source;
      seen_zext[state]      = zero_ext;
      seen_pc_write[state]  = pc_write;
      seen_pc_wcond[state]  = pc_write_cond;
      seen_reg_dst[state]   = reg_dst;
      seen_reg_write[state] = reg_write;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic r, input logic [5:0] op, input logic mr);
    applyStimulus(r, op, mr);
    tick();
  endtask

  task automatic clear_counts();
    cnt_ir_write  = 0;
    cnt_mem_write = 0;
    cnt_illegal   = 0;
  endtask

  // Cycles from FETCH to the next FETCH with mem_ready held high.
  task automatic measure(input string name, input logic [5:0] op, input int expected);
    int n;
    step(1'b0, op, 1'b1);
    n = 1;
    while (state != 4'd0 && n < 20) begin
      step(1'b0, op, 1'b1);
      n++;
    end
    checkOutput(name, n, expected);
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    checks_on = 0;
    exp_state = 0;
    clear_counts();
    for (int i = 0; i < 16; i++) begin
      seen_alu_op[i]    = '0;
      seen_pc_source[i] = '0;
      seen_zext[i]      = 1'b0;
      seen_pc_write[i]  = 1'b0;
      seen_pc_wcond[i]  = 1'b0;
      seen_reg_dst[i]   = 1'b0;
      seen_reg_write[i] = 1'b0;
    end
    rst       = 1'b1;
    opcode    = OP_R;
    mem_ready = 1'b0;
    tick();
    checks_on = 1;
    step(1'b1, OP_LW, 1'b0);

    // Write strobes are suppressed while reset is held, even in FETCH with
    // memory ready.
    applyStimulus(1'b1, OP_LW, 1'b1);
    checkOutput("rst_ir_write", int'(ir_write), 0);
    checkOutput("rst_pc_write", int'(pc_write), 0);
    tick();

    // Walk lw into a MEMREAD stall, then reset for two cycles.
    step(1'b0, OP_LW, 1'b1);
    step(1'b0, OP_LW, 1'b1);
    step(1'b0, OP_LW, 1'b1);
    checkOutput("in_memread", int'(state), 3);
    step(1'b0, OP_LW, 1'b0);
    step(1'b1, OP_LW, 1'b0);
    step(1'b1, OP_LW, 1'b0);
    applyStimulus(1'b0, OP_LW, 1'b0);
    checkOutput("post_rst_state", int'(state), 0);
    checkOutput("post_rst_mem_read", int'(mem_read), 1);
    checkOutput("post_rst_iord", int'(iord), 0);
    checkOutput("post_rst_reg_write", int'(reg_write), 0);
    checkOutput("post_rst_mem_write", int'(mem_write), 0);
    checkOutput("post_rst_ir_write", int'(ir_write), 0);
    tick();

    measure("lat_lw", OP_LW, 5);
    checkOutput("lw_memwb_reg_write", int'(seen_reg_write[4]), 1);

    measure("lat_r", OP_R, 4);
    checkOutput("r_exec_alu_op", int'(seen_alu_op[6]), 2);
    checkOutput("r_rwb_reg_dst", int'(seen_reg_dst[7]), 1);

    measure("lat_beq", OP_BEQ, 3);
    checkOutput("beq_alu_op", int'(seen_alu_op[8]), 1);
    checkOutput("beq_pc_write_cond", int'(seen_pc_wcond[8]), 1);
    checkOutput("beq_pc_source", int'(seen_pc_source[8]), 1);

    measure("lat_ori", OP_ORI, 4);
    checkOutput("ori_alu_op", int'(seen_alu_op[10]), 4);
    checkOutput("ori_zero_ext", int'(seen_zext[10]), 1);
    checkOutput("ori_iwb_reg_write", int'(seen_reg_write[11]), 1);
    measure("lat_andi", OP_ANDI, 4);
    checkOutput("andi_alu_op", int'(seen_alu_op[10]), 3);
    checkOutput("andi_zero_ext", int'(seen_zext[10]), 1);
    measure("lat_addi", OP_ADDI, 4);
    checkOutput("addi_alu_op", int'(seen_alu_op[10]), 0);
    checkOutput("addi_zero_ext", int'(seen_zext[10]), 0);

    measure("lat_sw", OP_SW, 4);

    // sw with three stall cycles in MEMWRITE.
    clear_counts();
    step(1'b0, OP_SW, 1'b1);
    step(1'b0, OP_SW, 1'b1);
    step(1'b0, OP_SW, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, OP_SW, 1'b0);
    step(1'b0, OP_SW, 1'b1);
    checkOutput("sw_mem_write_cycles", cnt_mem_write, 4);
    checkOutput("sw_back_to_fetch", int'(state), 0);

    // FETCH stalled for two cycles still loads IR exactly once.
    clear_counts();
    step(1'b0, OP_R, 1'b0);
    step(1'b0, OP_R, 1'b0);
    step(1'b0, OP_R, 1'b1);
    checkOutput("fetch_stall_ir_write", cnt_ir_write, 1);
    checkOutput("fetch_stall_decode", int'(state), 1);
    step(1'b0, OP_R, 1'b1);
    step(1'b0, OP_R, 1'b1);
    step(1'b0, OP_R, 1'b1);

    clear_counts();
    measure("lat_illegal", OP_BAD, 2);
    checkOutput("illegal_pulses", cnt_illegal, 1);

    measure("lat_j", OP_J, 3);
    checkOutput("j_pc_write", int'(seen_pc_write[9]), 1);
    checkOutput("j_pc_source", int'(seen_pc_source[9]), 2);

    step(1'b0, OP_R, 1'b0);
    step(1'b0, OP_R, 1'b0);
    checks_on = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
